// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared constants and types for the RF write-port arbiter.
//
// Build-wide constants (overridable from the command line):
//   `WIDTH          - RF data width (default 32)
//   `REG_ADDR_W     - register address width (5 for RV32I)
//   `WBA_FIFO_DEPTH - long-latency buffer depth; the arbiter is built for 2
//
// Contents:
//   REG_ADDR_W, FIFO_DEPTH, AGE_W - localparam copies of the constants above
//   grant_e                       - source selected for the RF write port
//   rd_onehot()                   - register address to 32-bit one-hot mask

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef WBA_FIFO_DEPTH
`define WBA_FIFO_DEPTH 2
`endif

package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = `REG_ADDR_W;
    localparam int FIFO_DEPTH = `WBA_FIFO_DEPTH;
    localparam int AGE_W      = 4;

    // Source selected for the RF write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE   = 2'd0,
        GRANT_PIPE   = 2'd1,
        GRANT_FIFO   = 2'd2,
        GRANT_BYPASS = 2'd3
    } grant_e;

    function automatic logic [31:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return 32'(1) << rd;
    endfunction

endpackage

// File: rtl/wba_fifo.sv
// wba_fifo: 2-entry buffer of long-latency results (rd + data) waiting for
// the RF write port.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (flushes contents)
//   push         - enqueue push_rd/push_data at the tail (never while full)
//   push_rd      - destination register of the pushed result
//   push_data    - data of the pushed result
//   pop          - drop the head entry (never while empty)
//   count        - number of valid entries (0..2)
//   head_rd      - destination register of the oldest entry
//   head_data    - data of the oldest entry
//   busy_mask    - bit n set while any valid entry targets xn
//
// Push and pop in the same cycle leave the count unchanged and advance the
// head. The busy mask is derived purely from registered entry state.

module wba_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = `WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [WIDTH-1:0]      head_data,
    output logic [31:0]           busy_mask
);

    logic [REG_ADDR_W-1:0] rd_q    [FIFO_DEPTH];
    logic [WIDTH-1:0]      data_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] valid_q;
    logic [1:0]            count_q;
    logic                  head_q;
    logic                  tail_ptr;

    // With two slots the tail is the head when empty and the other slot
    // when one entry is held; a full FIFO never sees a push.
    assign tail_ptr = head_q ^ count_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ~head_q;
            end
            // Push after pop: when one entry is held and both happen, the
            // tail slot differs from the popped head slot, so no conflict.
            if (push) begin
                rd_q[tail_ptr]    <= push_rd;
                data_q[tail_ptr]  <= push_data;
                valid_q[tail_ptr] <= 1'b1;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i]) begin
                busy_mask = busy_mask | rd_onehot(rd_q[i]);
            end
        end
    end

    assign count     = count_q;
    assign head_rd   = rd_q[head_q];
    assign head_data = data_q[head_q];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single RF write port between the in-order
// writeback stage and a long-latency result source. Long-latency results
// queue in a 2-entry FIFO; a starvation guard forces a one-cycle pipeline
// stall when the FIFO head has been blocked for MAX_WAIT cycles.
//
// Parameters:
//   WIDTH    - data width
//   MAX_WAIT - blocked cycles tolerated by the FIFO head (1..15)
//
// Ports:
//   i_clk, i_rst_n                     - clock, async active-low reset
//   i_wba_pipe_valid/_rd/_data         - writeback stage result
//   i_wba_lu_valid/_rd/_data           - long-latency result
//   o_wba_lu_ready                     - long-latency accept (FIFO not full)
//   o_wba_rf_we/_rd/_data              - registered RF write port
//   o_wba_stall                        - pipeline holds its writeback entry
//   o_wba_busy_mask                    - registers targeted by queued results
//
// Handshake: a long-latency result transfers on the cycle where
// i_wba_lu_valid && o_wba_lu_ready; the source holds valid/rd/data stable
// until that cycle. rd==0 transfers are accepted and dropped.
//
// Build option: define WBA_BYPASS_EN to let a long-latency result skip the
// FIFO when the FIFO is empty and the pipe has no non-zero write.

module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WIDTH    = `WIDTH,
    parameter int MAX_WAIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wba_pipe_valid,
    input  logic [REG_ADDR_W-1:0] i_wba_pipe_rd,
    input  logic [WIDTH-1:0]      i_wba_pipe_data,
    input  logic                  i_wba_lu_valid,
    input  logic [REG_ADDR_W-1:0] i_wba_lu_rd,
    input  logic [WIDTH-1:0]      i_wba_lu_data,
    output logic                  o_wba_lu_ready,
    output logic                  o_wba_rf_we,
    output logic [REG_ADDR_W-1:0] o_wba_rf_rd,
    output logic [WIDTH-1:0]      o_wba_rf_data,
    output logic                  o_wba_stall,
    output logic [31:0]           o_wba_busy_mask
);

    localparam logic [AGE_W-1:0] MAX_AGE = AGE_W'(MAX_WAIT);

    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [WIDTH-1:0]      head_data;
    logic                  fifo_push;
    logic                  fifo_pop;

    logic                  lu_accept;
    logic                  pipe_write;
    grant_e                grant;

    logic [AGE_W-1:0]      age_q;
    logic                  stall_q;

    assign fifo_empty     = (fifo_count == 2'd0);
    assign fifo_full      = (fifo_count == 2'(FIFO_DEPTH));
    assign o_wba_lu_ready = !fifo_full;

    // rd==0 results are architecturally dead: accepted but never written.
    assign lu_accept  = i_wba_lu_valid && !fifo_full && (i_wba_lu_rd != '0);
    assign pipe_write = i_wba_pipe_valid && (i_wba_pipe_rd != '0);

    always_comb begin
        grant = GRANT_NONE;
        if (stall_q && !fifo_empty) begin
            // Starvation slot: the pipeline is holding, so the head wins.
            grant = GRANT_FIFO;
        end else if (pipe_write) begin
            grant = GRANT_PIPE;
        end else if (!fifo_empty) begin
            grant = GRANT_FIFO;
`ifdef WBA_BYPASS_EN
        end else if (lu_accept) begin
            grant = GRANT_BYPASS;
`endif
        end
    end

    assign fifo_pop  = (grant == GRANT_FIFO);
    assign fifo_push = lu_accept && (grant != GRANT_BYPASS);

    wba_fifo #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_rd   (i_wba_lu_rd),
        .push_data (i_wba_lu_data),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head_rd   (head_rd),
        .head_data (head_data),
        .busy_mask (o_wba_busy_mask)
    );

    // Age counts the cycles the current head has been passed over. The
    // stall flag is raised only after a blocked cycle at full age, and since
    // a raised stall always grants the head, it lasts exactly one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            age_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            if (fifo_pop || fifo_empty) begin
                age_q <= '0;
            end else if (age_q != MAX_AGE) begin
                age_q <= age_q + AGE_W'(1);
            end
            stall_q <= !fifo_empty && !fifo_pop && (age_q == MAX_AGE);
        end
    end

    assign o_wba_stall = stall_q;

    // Registered write port; rd/data hold their last value on idle cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wba_rf_we   <= 1'b0;
            o_wba_rf_rd   <= '0;
            o_wba_rf_data <= '0;
        end else begin
            o_wba_rf_we <= (grant != GRANT_NONE);
            case (grant)
                GRANT_PIPE: begin
                    o_wba_rf_rd   <= i_wba_pipe_rd;
                    o_wba_rf_data <= i_wba_pipe_data;
                end
                GRANT_FIFO: begin
                    o_wba_rf_rd   <= head_rd;
                    o_wba_rf_data <= head_data;
                end
                GRANT_BYPASS: begin
                    o_wba_rf_rd   <= i_wba_lu_rd;
                    o_wba_rf_data <= i_wba_lu_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Register-file write-port arbiter for the pipelined RV32I core. Shares the single RF write port between the in-order writeback stage and a long-latency result source such as a multi-cycle divider or late load response. Long-latency results are buffered in a 2-entry FIFO, and a starvation guard stalls the pipeline when a buffered result waits too long. A pending-destination mask is exported to the hazard unit.

## Interface
- `WIDTH`, default `` `WIDTH `` (32): data width.
- `MAX_WAIT`, default 4: blocked cycles a FIFO head tolerates before a stall is forced; legal range 1..15.
- `i_clk` in 1: core clock, rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_wba_pipe_valid` in 1: writeback stage presents a result this cycle.
- `i_wba_pipe_rd` in 5: writeback destination register.
- `i_wba_pipe_data` in WIDTH: writeback data, taken from the writeback mux output.
- `i_wba_lu_valid` in 1: long-latency unit result valid.
- `i_wba_lu_rd` in 5: long-latency destination register.
- `i_wba_lu_data` in WIDTH: long-latency data.
- `o_wba_lu_ready` out 1: FIFO can accept; combinational, equals !full.
- `o_wba_rf_we` out 1: registered RF write enable.
- `o_wba_rf_rd` out 5: registered RF write address.
- `o_wba_rf_data` out WIDTH: registered RF write data.
- `o_wba_stall` out 1: registered; the pipeline must hold its writeback entry this cycle.
- `o_wba_busy_mask` out 32: bit n is set while any FIFO entry targets xn.

## Operation
- Long-latency transfer occurs on `i_wba_lu_valid && o_wba_lu_ready`.
  - rd==0: the transfer is accepted and discarded; nothing is enqueued.
  - Otherwise the result is enqueued at the tail.
- Grant evaluation, once per cycle, in priority order:
  - `o_wba_stall`=1 and FIFO non-empty: grant FIFO head. The pipe input is ignored; the pipeline re-presents it next cycle.
  - `i_wba_pipe_valid` with rd!=0: grant pipe.
  - FIFO non-empty: grant FIFO head and pop it.
  - Otherwise: no write.
- Pipe results with rd==0 never write. That cycle counts as a free slot for the FIFO.
- Granted entry is registered onto `o_wba_rf_*` with we=1. When nothing is granted, we=0 and rd/data hold their previous values.
- Age counter (4 bits):
  - Clears on pop and whenever the FIFO is empty.
  - Increments each cycle the head is non-empty and not granted.
  - Saturates at MAX_WAIT.
- `o_wba_stall` sets at the edge where age==MAX_WAIT and the head is not granted. It clears at the edge following the head grant, so it is asserted for exactly one cycle per starvation event.
- FIFO push and pop in the same cycle: count unchanged, head advances. Push is impossible when full (ready low).
- `o_wba_busy_mask` is the OR of one-hot(rd) over valid entries, registered with FIFO state. The hazard unit guarantees no younger pipe write to a masked rd, so ordering is preserved.
- Reset mid-operation flushes the FIFO. Buffered results are lost; the core restarts from the reset vector.

## Timing
- Reset values:
  - `o_wba_rf_we`=0, `o_wba_rf_rd`=0, `o_wba_rf_data`=0.
  - `o_wba_stall`=0, `o_wba_busy_mask`=0.
  - FIFO empty, so `o_wba_lu_ready`=1. Age=0.
- Pipe latency: write visible on `o_wba_rf_*` one cycle after presentation.
- Long-latency latency:
  - Minimum 2 cycles: enqueue edge, then grant edge.
  - With bypass (see Configuration): 1 cycle.
- Worst case for a FIFO head under continuous pipe traffic: MAX_WAIT+2 cycles.

## Configuration
- `WBA_BYPASS_EN` defined: when the FIFO is empty and no non-zero pipe write is presented, an accepted long-latency result with rd!=0 is granted directly in its arrival cycle. It is not enqueued and its busy bit never sets.
- `WBA_BYPASS_EN` undefined: every long-latency result passes through the FIFO.

## Structure
- `parameters.vh` holds `` `WIDTH ``, `` `REG_ADDR_W `` (5), and `` `WBA_FIFO_DEPTH `` (2). Depth is fixed at 2; the constant documents it.
- Sub-module `wba_fifo` is the 2-entry rd+data FIFO with count, head outputs, and busy-mask generation. The top level contains grant logic, the age counter, stall, and the output registers.

## Test plan
- Reset: hold `i_rst_n`=0 with random inputs → all outputs 0, `o_wba_lu_ready`=1.
- Pipe only: pipe rd=5, data=0x1234 → next cycle we=1, rd=5, data=0x1234. Pipe rd=0 → we=0.
- Contention: lu rd=7 data=0xAA while pipe continuously writes rd=3 → rd=3 writes continue; busy_mask bit 7 set; after MAX_WAIT=4 blocked cycles, stall=1 for one cycle, rd=7/0xAA is written in that cycle, mask clears.
- Full FIFO: two lu pushes (rd 8, 9) under pipe traffic → ready=0; a third lu valid is held and not lost; ready returns 1 the cycle after the first pop.
- Bypass: idle pipe, empty FIFO, lu rd=4 data=0x55 → write one cycle later with `WBA_BYPASS_EN` defined, two cycles later without.
- Async reset asserted with two entries queued → FIFO empty, mask=0, stall=0 immediately without a clock edge.
